// File: rtl/dm_mem_read_arbiter.sv
// Shares the capture-memory read port between the UART readback (tx) and the
// plot renderer (disp), and returns each word tagged with the requester that owns it.
module dm_mem_read_arbiter #(
  parameter int RD_LAT = 2,
  parameter int AW     = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_busy,
  input  logic          tx_req,
  input  logic [AW-1:0] tx_addr,
  output logic          tx_gnt,
  output logic          tx_valid,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_valid,
  output logic [AW-1:0] addraRead,
  input  logic [15:0]   douta0,
  input  logic [31:0]   douta1,
  input  logic [31:0]   douta2,
  output logic [15:0]   rd_data0,
  output logic [31:0]   rd_data1,
  output logic [31:0]   rd_data2,
  output logic          idle
);

  typedef enum logic {
    OWN_TX   = 1'b0,
    OWN_DISP = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } tag_t;

  tag_t   tag_pipe [RD_LAT];
  tag_t   tag_out;
  owner_e rr_next;
  logic   tx_elig;
  logic   disp_elig;
  logic   tx_win;
  logic   disp_win;
  logic   pipe_busy;

  // gnt is registered, so a requester granted last cycle still shows req with
  // the same address; it sits out one cycle so that address is not taken twice.
  assign tx_elig   = tx_req   & ~mem_busy & ~tx_gnt;
  assign disp_elig = disp_req & ~mem_busy & ~disp_gnt;

  assign tx_win   = tx_elig   & (~disp_elig | (rr_next == OWN_TX));
  assign disp_win = disp_elig & (~tx_elig   | (rr_next == OWN_DISP));

  assign tag_out = tag_pipe[RD_LAT-1];

  // NOTE: every variable written in always_comb is given a default first, so no latch is inferred.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_busy = pipe_busy | tag_pipe[i].vld;
    end
  end

  assign idle = ~pipe_busy & ~tx_gnt & ~disp_gnt;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the tag pipe is a few flops, not a RAM, so clearing it is how in-flight reads are dropped.
      for (int i = 0; i < RD_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
      rr_next    <= OWN_TX;
      tx_gnt     <= 1'b0;
      disp_gnt   <= 1'b0;
      tx_valid   <= 1'b0;
      disp_valid <= 1'b0;
      addraRead  <= '0;
      rd_data0   <= '0;
      rd_data1   <= '0;
      rd_data2   <= '0;
    end else begin
      tx_gnt   <= tx_win;
      disp_gnt <= disp_win;

      if (tx_win) begin
        addraRead <= tx_addr;
        rr_next   <= OWN_DISP;
      end else if (disp_win) begin
        addraRead <= disp_addr;
        rr_next   <= OWN_TX;
      end

      tag_pipe[0] <= '{vld: tx_win | disp_win, owner: (disp_win ? OWN_DISP : OWN_TX)};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end

      // The word for the tag leaving the pipe is on douta during this cycle.
      tx_valid   <= tag_out.vld & (tag_out.owner == OWN_TX);
      disp_valid <= tag_out.vld & (tag_out.owner == OWN_DISP);
      if (tag_out.vld) begin
        rd_data0 <= douta0;
        rd_data1 <= douta1;
        rd_data2 <= douta2;
      end
    end
  end

endmodule

// File: tb/tb_dm_mem_read_arbiter.sv
// Bench for dm_mem_read_arbiter: two instances (RD_LAT=2 and RD_LAT=1) share stimulus;
// each is compared every cycle against a queue-based model, plus directed literal checks.
module tb_dm_mem_read_arbiter;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_busy;
  logic          tx_req;
  logic [AW-1:0] tx_addr;
  logic          disp_req;
  logic [AW-1:0] disp_addr;

  logic [1:0]    tx_gnt_o;
  logic [1:0]    tx_valid_o;
  logic [1:0]    disp_gnt_o;
  logic [1:0]    disp_valid_o;
  logic [1:0]    idle_o;
  logic [AW-1:0] addr_o [2];
  logic [15:0]   rd0_o  [2];
  logic [31:0]   rd1_o  [2];
  logic [31:0]   rd2_o  [2];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit            disp;
    logic [AW-1:0] addr;
    int            due;
  } ret_t;

  always #5 clk = ~clk;

  // Memory contents as pure functions of the address.
  function automatic logic [15:0] dac(input logic [AW-1:0] a);
    return {2'b00, a} ^ 16'hBEEF;
  endfunction

  function automatic logic [31:0] adc0(input logic [AW-1:0] a);
    return {a[7:0], 10'h2A5, a};
  endfunction

  function automatic logic [31:0] adc1(input logic [AW-1:0] a);
    return {a, 18'h1B3C7} ^ 32'hFFFF_0000;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [lat_inst %0d] t=%0t: got 0x%0h, expected 0x%0h",
               name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : 1;

    logic [AW-1:0] ahist [4];
    logic [AW-1:0] mem_addr;
    logic [15:0]   d0;
    logic [31:0]   d1;
    logic [31:0]   d2;

    // BRAM stand-in: douta shows the word for the address presented LAT-1 cycles earlier.
    always @(posedge clk) begin
      ahist[0] <= addr_o[g];
      for (int i = 1; i < 4; i++) ahist[i] <= ahist[i-1];
    end
    assign mem_addr = (LAT == 1) ? addr_o[g] : ahist[(LAT > 1) ? LAT - 2 : 0];
    assign d0 = dac(mem_addr);
    assign d1 = adc0(mem_addr);
    assign d2 = adc1(mem_addr);

    dm_mem_read_arbiter #(.RD_LAT(LAT), .AW(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem_busy   (mem_busy),
      .tx_req     (tx_req),
      .tx_addr    (tx_addr),
      .tx_gnt     (tx_gnt_o[g]),
      .tx_valid   (tx_valid_o[g]),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .disp_gnt   (disp_gnt_o[g]),
      .disp_valid (disp_valid_o[g]),
      .addraRead  (addr_o[g]),
      .douta0     (d0),
      .douta1     (d1),
      .douta2     (d2),
      .rd_data0   (rd0_o[g]),
      .rd_data1   (rd1_o[g]),
      .rd_data2   (rd2_o[g]),
      .idle       (idle_o[g])
    );

    // Reference model: pending returns kept as a queue of {owner, address, due cycle}.
    ret_t          q[$];
    ret_t          r;
    bit            live = 1'b0;
    int            cyc;
    bit            last_disp;
    bit            tx_e, d_e, tx_w, d_w;
    bit            e_txg, e_dg, e_txv, e_dv, e_idle;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_rd0;
    logic [31:0]   e_rd1, e_rd2;

    initial forever begin
      @(posedge clk);
      if (!reset_n) begin
        q.delete();
        live      = 1'b1;
        cyc       = 0;
        last_disp = 1'b1;
        e_txg     = 1'b0;
        e_dg      = 1'b0;
        e_txv     = 1'b0;
        e_dv      = 1'b0;
        e_idle    = 1'b1;
        e_addr    = '0;
        e_rd0     = '0;
        e_rd1     = '0;
        e_rd2     = '0;
      end else if (live) begin
        tx_e = tx_req   && !mem_busy && !e_txg;
        d_e  = disp_req && !mem_busy && !e_dg;
        if (tx_e && d_e) begin
          tx_w = last_disp;
          d_w  = !last_disp;
        end else begin
          tx_w = tx_e;
          d_w  = d_e;
        end
        if (tx_w) begin
          q.push_back('{disp: 1'b0, addr: tx_addr, due: cyc + LAT + 1});
          e_addr    = tx_addr;
          last_disp = 1'b0;
        end
        if (d_w) begin
          q.push_back('{disp: 1'b1, addr: disp_addr, due: cyc + LAT + 1});
          e_addr    = disp_addr;
          last_disp = 1'b1;
        end
        e_txg = tx_w;
        e_dg  = d_w;
        cyc++;
        e_txv = 1'b0;
        e_dv  = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
          r = q.pop_front();
          e_txv = !r.disp;
          e_dv  = r.disp;
          e_rd0 = dac(r.addr);
          e_rd1 = adc0(r.addr);
          e_rd2 = adc1(r.addr);
        end
        e_idle = (q.size() == 0) && !tx_w && !d_w;
      end
    end

    initial forever begin
      @(negedge clk);
      if (live) begin
        check("tx_gnt",     g, 32'(tx_gnt_o[g]),     32'(e_txg));
        check("disp_gnt",   g, 32'(disp_gnt_o[g]),   32'(e_dg));
        check("tx_valid",   g, 32'(tx_valid_o[g]),   32'(e_txv));
        check("disp_valid", g, 32'(disp_valid_o[g]), 32'(e_dv));
        check("idle",       g, 32'(idle_o[g]),       32'(e_idle));
        check("addraRead",  g, 32'(addr_o[g]),       32'(e_addr));
        check("rd_data0",   g, 32'(rd0_o[g]),        32'(e_rd0));
        check("rd_data1",   g, rd1_o[g],             e_rd1);
        check("rd_data2",   g, rd2_o[g],             e_rd2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    tx_req   = 1'b0;
    disp_req = 1'b0;
    mem_busy = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  int busy_cnt;

  initial begin
    reset_n   = 1'b0;
    mem_busy  = 1'b0;
    tx_req    = 1'b0;
    tx_addr   = '0;
    disp_req  = 1'b0;
    disp_addr = '0;
    busy_cnt  = 0;
    step();
    step();
    reset_n = 1'b1;

    // Single tx read at 0x0005.
    tx_req  = 1'b1;
    tx_addr = 14'h0005;
    step();
    check("t1_gnt", 0, 32'(tx_gnt_o[0]), 1);
    check("t1_addr", 0, 32'(addr_o[0]), 32'h5);
    tx_req = 1'b0;
    step();
    check("t1_early_valid", 0, 32'(tx_valid_o[0]), 0);
    step();
    check("t1_valid", 0, 32'(tx_valid_o[0]), 1);
    check("t1_rd0", 0, 32'(rd0_o[0]), 32'hBEEA);
    idle_cycles(5);

    // Both requesting continuously from reset: strict alternation.
    reset_n = 1'b0;
    step();
    reset_n   = 1'b1;
    tx_req    = 1'b1;
    tx_addr   = 14'h0010;
    disp_req  = 1'b1;
    disp_addr = 14'h0020;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("t2_addr", 0, 32'(addr_o[0]), (k % 2 == 1) ? 32'h10 : 32'h20);
      check("t2_tx_gnt", 0, 32'(tx_gnt_o[0]), (k % 2 == 1) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) step();
    idle_cycles(6);

    // tx alone with unchanged address: grant every other cycle.
    tx_req  = 1'b1;
    tx_addr = 14'h0003;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 6) tx_req = 1'b0;
      check("t3_tx_gnt", 0, 32'(tx_gnt_o[0]), (k % 2 == 1) ? 1 : 0);
    end
    idle_cycles(5);

    // mem_busy right after a disp grant, with tx waiting.
    disp_req  = 1'b1;
    disp_addr = 14'h0021;
    step();
    check("t4_disp_gnt", 0, 32'(disp_gnt_o[0]), 1);
    disp_req = 1'b0;
    mem_busy = 1'b1;
    tx_req   = 1'b1;
    tx_addr  = 14'h0007;
    for (int k = 2; k <= 5; k++) begin
      step();
      check("t4_tx_gnt_blocked", 0, 32'(tx_gnt_o[0]), 0);
      if (k == 3) check("t4_disp_valid", 0, 32'(disp_valid_o[0]), 1);
      if (k == 5) mem_busy = 1'b0;
    end
    step();
    check("t4_tx_gnt_resume", 0, 32'(tx_gnt_o[0]), 1);
    tx_req = 1'b0;
    idle_cycles(5);

    // Reset while two reads are in flight.
    tx_req    = 1'b1;
    tx_addr   = 14'h0100;
    disp_req  = 1'b1;
    disp_addr = 14'h0200;
    step();
    step();
    tx_req   = 1'b0;
    disp_req = 1'b0;
    reset_n  = 1'b0;
    step();
    reset_n = 1'b1;
    check("t5_idle", 0, 32'(idle_o[0]), 1);
    check("t5_rd0", 0, 32'(rd0_o[0]), 0);
    check("t5_rd1", 0, rd1_o[0], 0);
    check("t5_rd2", 0, rd2_o[0], 0);
    for (int k = 0; k < 6; k++) begin
      check("t5_no_valid", 0, 32'({tx_valid_o, disp_valid_o}), 0);
      step();
    end
    tx_req   = 1'b1;
    disp_req = 1'b1;
    step();
    check("t5_tx_first", 0, 32'(tx_gnt_o[0]), 1);
    check("t5_disp_not_first", 0, 32'(disp_gnt_o[0]), 0);
    idle_cycles(6);

    // Top address on the RD_LAT=1 instance.
    disp_req  = 1'b1;
    disp_addr = 14'h3FFF;
    step();
    check("t6_gnt", 1, 32'(disp_gnt_o[1]), 1);
    check("t6_early_valid", 1, 32'(disp_valid_o[1]), 0);
    disp_req = 1'b0;
    step();
    check("t6_valid", 1, 32'(disp_valid_o[1]), 1);
    check("t6_rd0", 1, 32'(rd0_o[1]), 32'h8110);
    idle_cycles(5);

    // Randomized traffic with busy bursts, dropped requests and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;

      if (busy_cnt > 0) begin
        busy_cnt--;
        mem_busy = 1'b1;
      end else begin
        mem_busy = 1'b0;
        if ($urandom_range(0, 39) == 0) busy_cnt = int'($urandom_range(1, 8));
      end

      if (tx_req && tx_gnt_o[0]) begin
        tx_req  = ($urandom_range(0, 2) != 0);
        tx_addr = AW'($urandom());
      end else if (!tx_req) begin
        tx_req  = ($urandom_range(0, 1) == 1);
        tx_addr = AW'($urandom());
      end else if ($urandom_range(0, 19) == 0) begin
        tx_req = 1'b0;
      end

      if (disp_req && disp_gnt_o[0]) begin
        disp_req  = ($urandom_range(0, 2) != 0);
        disp_addr = AW'($urandom());
      end else if (!disp_req) begin
        disp_req  = ($urandom_range(0, 1) == 1);
        disp_addr = AW'($urandom());
      end else if ($urandom_range(0, 19) == 0) begin
        disp_req = 1'b0;
      end

      step();
    end
    reset_n = 1'b1;
    idle_cycles(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_mem_read_arbiter.md
Name: dm_mem_read_arbiter

Overview:
- Shares the single read address port (addraRead) of the DAC/ADC capture memories between two readers: the UART readback sequencer (tx) and the video plot renderer (disp).
- Registers the selected address, tracks each read in flight through the BRAM latency, and returns the douta0/douta1/douta2 words on a shared return bus. A valid strobe marks which requester owns each word.
- Stops granting while the acquisition FSM owns the memories for writing.

Parameters:
- RD_LAT, 2, BRAM read latency in clk cycles, from addraRead registered to douta valid; legal range 1..4.
- AW, 14, memory address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- mem_busy  in  1  acquisition writer owns memories; no new grants while high
- tx_req  in  1  tx read request; hold high with tx_addr stable until tx_gnt
- tx_addr  in  AW  tx read address
- tx_gnt  out  1  one-cycle pulse: tx_addr accepted
- tx_valid  out  1  one-cycle pulse: rd_data* holds the tx word
- disp_req  in  1  disp read request
- disp_addr  in  AW  disp read address
- disp_gnt  out  1  one-cycle pulse: disp_addr accepted
- disp_valid  out  1  one-cycle pulse: rd_data* holds the disp word
- addraRead  out  AW  read address to memories
- douta0  in  16  DAC memory read data
- douta1  in  32  ADC0 memory read data
- douta2  in  32  ADC1 memory read data
- rd_data0  out  16  returned DAC word
- rd_data1  out  32  returned ADC0 word
- rd_data2  out  32  returned ADC1 word
- idle  out  1  high when no read is in flight and no grant is pending

Behaviour:
- Reset (reset_n low at a clk edge):
  - addraRead, all gnt/valid, rd_data*, and the in-flight tag pipe go to 0; idle goes to 1.
  - The round-robin pointer goes to "tx next".
  - Reads in flight are discarded, and no valid is produced for them.
- Eligibility in cycle N:
  - A requester is eligible if its req=1, mem_busy=0, and it was not granted in cycle N-1.
  - The N-1 exclusion is required because gnt is registered; it stops an unchanged address from being re-accepted.
- Arbitration:
  - If exactly one requester is eligible, it wins.
  - If both are eligible, the one not granted most recently wins (round-robin). The pointer updates only on a grant.
- Grant at the edge ending cycle N: addraRead <= winner addr; winner gnt <= 1 for cycle N+1; tag {valid, owner} enters stage 0 of an RD_LAT-deep shift pipe.
- Return:
  - When the tag reaches the pipe end, the matching *_valid pulses for one cycle, and rd_data0/1/2 <= douta0/1/2 on that same edge.
  - Request-to-valid latency is RD_LAT+1 cycles after the req cycle in which the grant was decided.
- rd_data* hold their last value when no valid is asserted.
- Throughput:
  - With both requesters continuously asserting, grants alternate tx, disp, tx, … one per cycle (full port utilisation).
  - A single requester gets at most one grant every 2 cycles.
- addraRead holds its last granted address when no grant occurs.
- mem_busy:
  - Blocks new grants in the same cycle it is sampled high. In-flight tags still drain and produce valids.
  - The writer must raise mem_busy at least RD_LAT+1 cycles before driving wea; this is a system rule and is not checked here.
  - Requests pending during mem_busy stay pending, and arbitration resumes the cycle after mem_busy falls.
- A requester dropping req before gnt is legal; it forfeits that request and no valid follows.
- idle = (no tag in pipe) and (no gnt this cycle).

Test Plan:
- Single tx read, RD_LAT=2: tx_req=1, tx_addr=0x0005 in cycle 0 → tx_gnt and addraRead=0x0005 in cycle 1; tx_valid in cycle 3 with rd_data1 equal to the model's ADC0[5]; disp_valid never asserts.
- Both requesting continuously from reset, tx_addr=0x10, disp_addr=0x20: grants go tx, disp, tx, disp… The addraRead sequence is 0x10, 0x20, 0x10, 0x20, and the valids follow with the same owner order, each RD_LAT cycles after its grant.
- tx alone holding req=1 for 6 cycles with unchanged addr=0x3: tx_gnt pulses in cycles 1, 3 and 5 only, never back-to-back.
- mem_busy=1 asserted the cycle after a disp grant, while tx_req=1: the disp_valid still arrives, and no tx_gnt occurs while mem_busy=1. tx_gnt appears in the second cycle after mem_busy falls.
- reset_n=0 for one cycle while two reads are in flight: no valid emerges afterwards; idle=1, rd_data*=0, and the next grant goes to tx when both request.
- RD_LAT=1 build: single disp read at 0x3FFF (top address) → disp_valid exactly 2 cycles after the req cycle, with rd_data0 equal to DAC[0x3FFF].
